// File: rtl/ib_ctlr.sv
// ib_ctlr: inbound H2C stream packer.
// Pairs 64-bit AXI-Stream beats into 128-bit words, writes them into a banked
// RAM, closes a bank on packet end or when full, hands closed banks to the
// consumer, and raises a user interrupt for every closed bank.
module ib_ctlr #(
  parameter int unsigned NUM_BANK   = 8,
  parameter int unsigned BANK_DEPTH = 512,
  parameter int unsigned ADDR_W     = 12
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [63:0]                   m_axis_h2c_tdata_0,
  input  logic [7:0]                    m_axis_h2c_tkeep_0,
  input  logic                          m_axis_h2c_tlast_0,
  input  logic                          m_axis_h2c_tvalid_0,
  output logic                          m_axis_h2c_tready_0,
  output logic                          WrEn,
  output logic [ADDR_W-1:0]             WrAddr,
  output logic [127:0]                  WrData,
  output logic [NUM_BANK-1:0]           BankValid,
  input  logic [NUM_BANK-1:0]           BankRelease,
  output logic                          BankDoneStb,
  output logic [$clog2(NUM_BANK)-1:0]   BankDoneIdx,
  output logic [$clog2(BANK_DEPTH):0]   BankDoneLen,
  output logic [3:0]                    usr_irq_req,
  input  logic [3:0]                    usr_irq_ack,
  input  logic                          msi_enable
);

  localparam int unsigned BANK_W = $clog2(NUM_BANK);
  localparam int unsigned OFF_W  = $clog2(BANK_DEPTH);
  localparam int unsigned LEN_W  = OFF_W + 1;
  localparam logic [OFF_W-1:0] OFF_LAST = OFF_W'(BANK_DEPTH - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LO,
    S_HI,
    S_WR,
    S_CLOSE
  } state_t;

  state_t              state;
  logic [BANK_W-1:0]   cur_bank;
  logic [OFF_W-1:0]    offset;
  logic                close_q;
  logic                beat_acc;
  logic [63:0]         beat_masked;
  logic [NUM_BANK-1:0] bank_set;
  logic                bank_closing;
  logic                irq_pend;
  logic                unused_ack;

  // Only bit 0 of the acknowledge vector carries meaning.
  assign unused_ack = ^usr_irq_ack[3:1];

  assign beat_acc = m_axis_h2c_tvalid_0 & m_axis_h2c_tready_0;

  // Disabled byte lanes are written as zero rather than keeping stale data.
  function automatic logic [63:0] mask_beat(input logic [63:0] d, input logic [7:0] k);
    logic [63:0] m;
    m = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (k[i]) m[8*i +: 8] = d[8*i +: 8];
    end
    return m;
  endfunction

  // Byte-lane masking of the incoming beat.
  always_comb begin
    beat_masked = mask_beat(m_axis_h2c_tdata_0, m_axis_h2c_tkeep_0);
  end

  // Bank closes after the write cycle of a packet-final word or the last slot.
  always_comb begin
    bank_set     = '0;
    bank_closing = (state == S_WR) && (close_q || (offset == OFF_LAST));
    if (bank_closing) bank_set[cur_bank] = 1'b1;
  end

  // Main packing FSM; all stream and RAM-side outputs are registered here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state               <= S_IDLE;
      m_axis_h2c_tready_0 <= 1'b0;
      WrEn                <= 1'b0;
      WrAddr              <= '0;
      WrData              <= '0;
      cur_bank            <= '0;
      offset              <= '0;
      close_q             <= 1'b0;
      BankDoneStb         <= 1'b0;
      BankDoneIdx         <= '0;
      BankDoneLen         <= '0;
    end else begin
      WrEn        <= 1'b0;
      BankDoneStb <= 1'b0;
      case (state)
        S_IDLE: begin
          // Stall here while the consumer still owns the target bank.
          if (!BankValid[cur_bank]) begin
            state               <= S_LO;
            m_axis_h2c_tready_0 <= 1'b1;
          end
        end
        S_LO: begin
          if (beat_acc) begin
            WrData <= {64'h0, beat_masked};
            if (m_axis_h2c_tlast_0) begin
              state               <= S_WR;
              m_axis_h2c_tready_0 <= 1'b0;
              WrEn                <= 1'b1;
              WrAddr              <= {cur_bank, offset};
              close_q             <= 1'b1;
            end else begin
              state <= S_HI;
            end
          end
        end
        S_HI: begin
          if (beat_acc) begin
            WrData[127:64]      <= beat_masked;
            state               <= S_WR;
            m_axis_h2c_tready_0 <= 1'b0;
            WrEn                <= 1'b1;
            WrAddr              <= {cur_bank, offset};
            close_q             <= m_axis_h2c_tlast_0;
          end
        end
        S_WR: begin
          offset <= offset + OFF_W'(1);
          if (bank_closing) begin
            state       <= S_CLOSE;
            BankDoneStb <= 1'b1;
            BankDoneIdx <= cur_bank;
            BankDoneLen <= {1'b0, offset} + LEN_W'(1);
          end else begin
            state               <= S_LO;
            m_axis_h2c_tready_0 <= 1'b1;
          end
        end
        S_CLOSE: begin
          cur_bank <= cur_bank + BANK_W'(1);
          offset   <= '0;
          close_q  <= 1'b0;
          state    <= S_IDLE;
        end
        default: begin
          state               <= S_IDLE;
          m_axis_h2c_tready_0 <= 1'b0;
        end
      endcase
    end
  end

  // Bank ownership: set on close, cleared by the consumer's release pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      BankValid <= '0;
    end else begin
      BankValid <= (BankValid & ~BankRelease) | bank_set;
    end
  end

  // Interrupt pending flag; a new bank-done wins over a same-cycle acknowledge.
  always_ff @(posedge clk) begin
    if (rst) begin
      irq_pend <= 1'b0;
    end else if (!msi_enable) begin
      irq_pend <= 1'b0;
    end else if (BankDoneStb) begin
      irq_pend <= 1'b1;
    end else if (usr_irq_ack[0]) begin
      irq_pend <= 1'b0;
    end
  end

  assign usr_irq_req = {3'b000, irq_pend};

endmodule

// File: tb/tb_ib_ctlr.sv
// tb_ib_ctlr: randomized scoreboard bench for the inbound packing controller.
module tb_ib_ctlr;

  localparam int unsigned NB    = 8;
  localparam int unsigned DEPTH = 512;

  logic         clk = 1'b0;
  logic         rst;
  logic [63:0]  tdata;
  logic [7:0]   tkeep;
  logic         tlast;
  logic         tvalid;
  logic         tready;
  logic         WrEn;
  logic [11:0]  WrAddr;
  logic [127:0] WrData;
  logic [7:0]   BankValid;
  logic [7:0]   BankRelease;
  logic         BankDoneStb;
  logic [2:0]   BankDoneIdx;
  logic [9:0]   BankDoneLen;
  logic [3:0]   usr_irq_req;
  logic [3:0]   usr_irq_ack;
  logic         msi_enable;

  always #5 clk = ~clk;

  ib_ctlr #(.NUM_BANK(8), .BANK_DEPTH(512), .ADDR_W(12)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .m_axis_h2c_tdata_0  (tdata),
    .m_axis_h2c_tkeep_0  (tkeep),
    .m_axis_h2c_tlast_0  (tlast),
    .m_axis_h2c_tvalid_0 (tvalid),
    .m_axis_h2c_tready_0 (tready),
    .WrEn                (WrEn),
    .WrAddr              (WrAddr),
    .WrData              (WrData),
    .BankValid           (BankValid),
    .BankRelease         (BankRelease),
    .BankDoneStb         (BankDoneStb),
    .BankDoneIdx         (BankDoneIdx),
    .BankDoneLen         (BankDoneLen),
    .usr_irq_req         (usr_irq_req),
    .usr_irq_ack         (usr_irq_ack),
    .msi_enable          (msi_enable)
  );

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  function automatic void chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Reference model: a word is two beats (or one beat at packet end);
  // a bank closes on packet end or when it holds DEPTH words.
  typedef struct { logic [11:0] addr; logic [127:0] data; } wr_t;
  typedef struct { logic [2:0] idx; logic [9:0] len; } done_t;
  wr_t   wq[$];
  done_t dq[$];
  int unsigned m_bank = 0;
  int unsigned m_off  = 0;
  bit          m_has_lo = 0;
  logic [63:0] m_lo = '0;

  function automatic void model_reset();
    m_bank = 0; m_off = 0; m_has_lo = 0; m_lo = '0;
  endfunction

  function automatic void model_emit(input logic [127:0] w, input bit close);
    wq.push_back('{addr: 12'(m_bank * DEPTH + m_off), data: w});
    m_off++;
    if (close || m_off == DEPTH) begin
      dq.push_back('{idx: 3'(m_bank), len: 10'(m_off)});
      m_bank = (m_bank + 1) % NB;
      m_off  = 0;
    end
  endfunction

  function automatic void model_beat(input logic [63:0] d, input logic [7:0] k, input bit l);
    logic [63:0] md;
    md = '0;
    for (int unsigned i = 0; i < 8; i++) if (k[i]) md[8*i +: 8] = d[8*i +: 8];
    if (!m_has_lo) begin
      if (l) model_emit({64'h0, md}, 1'b1);
      else begin m_lo = md; m_has_lo = 1; end
    end else begin
      m_has_lo = 0;
      model_emit({md, m_lo}, l);
    end
  endfunction

  // Inputs as seen by the DUT at each rising edge.
  logic       s_rst = 1'b1;
  logic [7:0] s_rel = '0;
  logic [3:0] s_ack = '0;
  logic       s_msi = 1'b0;
  initial forever begin
    @(posedge clk);
    s_rst = rst; s_rel = BankRelease; s_ack = usr_irq_ack; s_msi = msi_enable;
  end

  // Monitor: pops expected writes/closures and tracks bank ownership and IRQ.
  logic [7:0] exp_bv = '0;
  bit         exp_irq = 0;
  bit         stb_prev = 0;
  initial forever begin
    wr_t        w;
    done_t      d;
    logic [7:0] setb;
    bit         stb_now;
    @(negedge clk);
    setb = '0; stb_now = 0;
    if (WrEn !== 1'b0) begin
      if (wq.size() == 0) chk("wr_unexpected", 128'(WrEn), 128'(0));
      else begin
        w = wq.pop_front();
        chk("wr_addr", 128'(WrAddr), 128'(w.addr));
        chk("wr_data", WrData, w.data);
      end
    end
    if (BankDoneStb !== 1'b0) begin
      if (dq.size() == 0) chk("done_unexpected", 128'(BankDoneStb), 128'(0));
      else begin
        d = dq.pop_front();
        chk("done_idx", 128'(BankDoneIdx), 128'(d.idx));
        chk("done_len", 128'(BankDoneLen), 128'(d.len));
        setb[d.idx] = 1'b1;
        stb_now = 1;
      end
    end
    if (s_rst) exp_bv = '0;
    else exp_bv = (exp_bv & ~s_rel) | setb;
    chk("bank_valid", 128'(BankValid), 128'(exp_bv));
    if (s_rst) exp_irq = 0;
    else if (!s_msi) exp_irq = 0;
    else if (stb_prev) exp_irq = 1;
    else if (s_ack[0]) exp_irq = 0;
    chk("usr_irq_req", 128'(usr_irq_req), 128'({3'b000, exp_irq}));
    stb_prev = stb_now;
  end

  // Consumer: randomly releases one currently-owned bank.
  bit rel_auto = 0;
  initial forever begin
    int unsigned s;
    @(posedge clk); #1;
    if (rel_auto) begin
      BankRelease = '0;
      if (BankValid != '0 && $urandom_range(0, 2) == 0) begin
        s = $urandom_range(0, 7);
        for (int unsigned j = 0; j < 8; j++) begin
          if (BankValid[3'((s + j) % 8)]) begin
            BankRelease[3'((s + j) % 8)] = 1'b1;
            break;
          end
        end
      end
    end
  end

  // XDMA side: random acknowledges, with noise on the unused bits.
  bit ack_auto = 0;
  initial forever begin
    @(posedge clk); #1;
    if (ack_auto) begin
      usr_irq_ack = 4'($urandom_range(0, 15)) & 4'hE;
      if (usr_irq_req[0] && $urandom_range(0, 2) == 0) usr_irq_ack[0] = 1'b1;
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
    $fatal(1, "watchdog");
  end

  task automatic send_beat(input logic [63:0] d, input logic [7:0] k, input bit l, input int unsigned gap);
    int unsigned cnt;
    if (gap > 0) begin repeat (gap) @(posedge clk); #1; end
    model_beat(d, k, l);
    tdata = d; tkeep = k; tlast = l; tvalid = 1'b1;
    cnt = 0;
    do begin @(posedge clk); cnt++; end while (tready !== 1'b1 && cnt < 3000);
    if (tready !== 1'b1) chk("tready_timeout", 128'(tready), 128'(1));
    #1; tvalid = 1'b0; tlast = 1'b0;
  endtask

  task automatic send_pkt(input int unsigned n, input bit rnd);
    logic [63:0] d;
    logic [7:0]  k;
    int unsigned sel;
    for (int unsigned i = 0; i < n; i++) begin
      d = {$urandom, $urandom};
      k = 8'hFF;
      if (rnd) begin
        sel = $urandom_range(0, 3);
        if (sel == 0) k = 8'($urandom);
        else if (sel == 1) k = 8'h00;
      end
      send_beat(d, k, i == n - 1, rnd ? $urandom_range(0, 2) : 0);
    end
  endtask

  task automatic wait_drain();
    int unsigned c;
    c = 0;
    while ((wq.size() != 0 || dq.size() != 0) && c < 20000) begin @(posedge clk); c++; end
    repeat (4) @(posedge clk);
    #1;
    chk("drain", 128'(wq.size() + dq.size()), 128'(0));
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_tready"}, 128'(tready), 128'(0));
    chk({tag, "_wren"}, 128'(WrEn), 128'(0));
    chk({tag, "_wraddr"}, 128'(WrAddr), 128'(0));
    chk({tag, "_wrdata"}, WrData, 128'(0));
    chk({tag, "_bankvalid"}, 128'(BankValid), 128'(0));
    chk({tag, "_donestb"}, 128'(BankDoneStb), 128'(0));
    chk({tag, "_doneidx"}, 128'(BankDoneIdx), 128'(0));
    chk({tag, "_donelen"}, 128'(BankDoneLen), 128'(0));
    chk({tag, "_irq"}, 128'(usr_irq_req), 128'(0));
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_zero("reset");
    @(posedge clk); #1;
  endtask

  initial begin
    int unsigned cnt;
    bit          got;
    rst = 1'b1; tvalid = 1'b0; tdata = '0; tkeep = '0; tlast = 1'b0;
    BankRelease = '0; usr_irq_ack = '0; msi_enable = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_zero("init");
    @(posedge clk); #1;

    // Single 4-beat packet -> two words in bank 0
    for (int unsigned i = 1; i <= 4; i++) send_beat(64'(i), 8'hFF, i == 4, 0);
    wait_drain();
    chk("single_irq_held", 128'(usr_irq_req[0]), 128'(1));
    usr_irq_ack = 4'h1; @(posedge clk); #1; usr_irq_ack = '0;

    // Odd beat count with partial keep on the last beat
    send_beat(64'h0123456789ABCDEF, 8'hFF, 0, 0);
    send_beat(64'hFEDCBA9876543210, 8'hFF, 0, 0);
    send_beat(64'hAABBCCDD11223344, 8'h0F, 1, 0);
    wait_drain();

    // Randomized traffic with a live consumer and interrupt handler
    rel_auto = 1; ack_auto = 1;
    for (int unsigned p = 0; p < 60; p++) send_pkt($urandom_range(1, 12), 1);
    wait_drain();

    // Acknowledge colliding with a new bank-done keeps the request up
    ack_auto = 0; usr_irq_ack = '0;
    send_pkt(2, 0);
    wait_drain();
    chk("collide_pre_irq", 128'(usr_irq_req[0]), 128'(1));
    send_pkt(2, 0);
    @(posedge clk); #1 usr_irq_ack = 4'h1;
    @(posedge clk); #1 usr_irq_ack = '0;
    @(negedge clk);
    chk("collide_irq", 128'(usr_irq_req[0]), 128'(1));
    wait_drain();
    usr_irq_ack = 4'h1; @(posedge clk); #1; usr_irq_ack = '0;

    // Interrupts gated off
    msi_enable = 1'b0;
    send_pkt(3, 0);
    wait_drain();
    chk("msi_off_irq", 128'(usr_irq_req), 128'(0));
    msi_enable = 1'b1;

    // Back-pressure: fill every bank with no release
    rel_auto = 0; BankRelease = '0;
    do_reset();
    for (int unsigned p = 0; p < NB; p++) send_pkt(2, 0);
    wait_drain();
    chk("bp_all_valid", 128'(BankValid), 128'(8'hFF));
    model_beat(64'h5A5A_0000_C3C3_0001, 8'hFF, 1);
    tdata = 64'h5A5A_0000_C3C3_0001; tkeep = 8'hFF; tlast = 1'b1; tvalid = 1'b1;
    for (int unsigned i = 0; i < 20; i++) begin
      @(posedge clk);
      chk("bp_tready_low", 128'(tready), 128'(0));
    end
    #1 BankRelease = 8'h01;
    @(posedge clk); cnt = 1; got = (tready === 1'b1);
    #1 BankRelease = '0;
    while (!got && cnt < 10) begin @(posedge clk); cnt++; got = (tready === 1'b1); end
    if (!got || cnt > 3) chk("bp_resume_cycles", 128'(cnt), 128'(3));
    else chk("bp_resume", 128'(tready), 128'(1));
    #1 tvalid = 1'b0; tlast = 1'b0;
    wait_drain();

    // One packet spanning two banks
    do_reset();
    for (int unsigned i = 0; i < 1030; i++) send_beat(64'(i + 1), 8'hFF, i == 1029, 0);
    wait_drain();
    chk("overflow_valid", 128'(BankValid), 128'(8'h03));

    // Reset after the first beat of a word
    send_beat(64'hDEAD_BEEF_0000_0001, 8'hFF, 0, 0);
    rst = 1'b1;
    model_reset();
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check_zero("midrst");
    @(posedge clk); #1;
    send_pkt(2, 0);
    wait_drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
